// File: rtl/mips_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mips_dmem_responder
// Description : Data-side memory responder for the single-cycle MIPS core.
//               Word RAM plus memory-mapped game IO (key FIFO, cycle timer,
//               LFSR random source, LED register). Reads are combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_dmem_responder #(
  parameter int          RAM_WORDS = 64,
  parameter int          KEY_DEPTH = 4,
  parameter logic [31:0] LFSR_POLY = 32'h8020_0003
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  output logic [7:0]  leds
);

  localparam int C_RAM_AW = $clog2(RAM_WORDS);
  localparam int C_KEY_PW = $clog2(KEY_DEPTH);

  localparam logic [15:0]         C_IO_PAGE    = 16'hFFFF;
  localparam logic [13:0]         C_REG_STAT   = 14'd0;
  localparam logic [13:0]         C_REG_DATA   = 14'd1;
  localparam logic [13:0]         C_REG_TIMER  = 14'd2;
  localparam logic [13:0]         C_REG_RAND   = 14'd3;
  localparam logic [13:0]         C_REG_LED    = 14'd4;
  localparam logic [C_KEY_PW:0]   C_KEY_FULL   = (C_KEY_PW + 1)'(KEY_DEPTH);

  // Storage arrays: not reset, contents are don't-care until written.
  logic [31:0] mem_q     [RAM_WORDS];
  logic [7:0]  key_mem_q [KEY_DEPTH];

  // Architectural registers and their next-state values.
  logic [C_KEY_PW-1:0] wptr_q,  wptr_d;
  logic [C_KEY_PW-1:0] rptr_q,  rptr_d;
  logic [C_KEY_PW:0]   count_q, count_d;
  logic                ovf_q,   ovf_d;
  logic [31:0]         timer_q, timer_d;
  logic [31:0]         lfsr_q,  lfsr_d;
  logic [7:0]          leds_q,  leds_d;

  // Address decode.
  logic                w_ram_sel;
  logic [C_RAM_AW-1:0] w_ram_idx;
  logic                w_io_sel;
  logic [13:0]         w_io_reg;
  logic                w_wr_stat, w_wr_data, w_wr_timer, w_wr_rand, w_wr_led;
  logic                w_full, w_pop, w_push;
  logic [31:0]         w_lfsr_step;
  logic [31:0]         w_cnt_ext;
  logic                w_unused;

  assign w_ram_sel  = (aluout[31:C_RAM_AW+2] == '0);
  assign w_ram_idx  = aluout[C_RAM_AW+1:2];
  assign w_io_sel   = (aluout[31:16] == C_IO_PAGE);
  assign w_io_reg   = aluout[15:2];

  assign w_wr_stat  = memwrite && w_io_sel && (w_io_reg == C_REG_STAT);
  assign w_wr_data  = memwrite && w_io_sel && (w_io_reg == C_REG_DATA);
  assign w_wr_timer = memwrite && w_io_sel && (w_io_reg == C_REG_TIMER);
  assign w_wr_rand  = memwrite && w_io_sel && (w_io_reg == C_REG_RAND);
  assign w_wr_led   = memwrite && w_io_sel && (w_io_reg == C_REG_LED);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  // when it is also being popped (the head is dropped, count unchanged).
  assign w_full     = (count_q == C_KEY_FULL);
  assign w_pop      = w_wr_data && (count_q != '0);
  assign w_push     = key_valid && (!w_full || w_pop);

  // Galois step: shift right, fold in the taps when the bit shifted out is 1.
  assign w_lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);

  assign w_cnt_ext  = 32'(count_q);
  assign w_unused   = &{1'b0, aluout[1:0], w_cnt_ext[31:4]};
  assign leds       = leds_q;

  // Next-state logic for the FIFO control, timer, LFSR and LED registers.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    timer_d = timer_q + 32'd1;
    lfsr_d  = w_lfsr_step;
    leds_d  = leds_q;

    if (w_push) wptr_d = wptr_q + 1'b1;
    if (w_pop)  rptr_d = rptr_q + 1'b1;
    if (w_push && !w_pop)      count_d = count_q + 1'b1;
    else if (w_pop && !w_push) count_d = count_q - 1'b1;

    // Setting overflow takes priority over a clear in the same cycle.
    if (key_valid && w_full && !w_pop) ovf_d = 1'b1;
    else if (w_wr_stat)                ovf_d = 1'b0;

    if (w_wr_timer) timer_d = writedata;
    if (w_wr_rand)  lfsr_d  = (writedata == 32'h0) ? 32'h1 : writedata;
    if (w_wr_led)   leds_d  = writedata[7:0];
  end

  // Register update with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      timer_q <= 32'h0;
      lfsr_q  <= 32'h1;
      leds_q  <= 8'h0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      timer_q <= timer_d;
      lfsr_q  <= lfsr_d;
      leds_q  <= leds_d;
    end
  end

  // Data RAM write port.
  always_ff @(posedge clk) begin
    if (memwrite && w_ram_sel) mem_q[w_ram_idx] <= writedata;
  end

  // Key FIFO storage write port.
  always_ff @(posedge clk) begin
    if (w_push) key_mem_q[wptr_q] <= key_code;
  end

  // Combinational read mux following the address map.
  always_comb begin
    readdata = 32'h0;
    if (w_ram_sel) begin
      readdata = mem_q[w_ram_idx];
    end else if (w_io_sel) begin
      case (w_io_reg)
        C_REG_STAT:  readdata = {24'h0, ovf_q, 3'b000, w_cnt_ext[3:0]};
        C_REG_DATA:  readdata = (count_q != '0) ? {24'h0, key_mem_q[rptr_q]} : 32'h0;
        C_REG_TIMER: readdata = timer_q;
        C_REG_RAND:  readdata = lfsr_q;
        C_REG_LED:   readdata = {24'h0, leds_q};
        default:     readdata = 32'h0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_dmem_responder
// Description : Self-checking scoreboard bench for mips_dmem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_dmem_responder;

  localparam logic [31:0] C_POLY  = 32'h8020_0003;
  localparam logic [31:0] A_STAT  = 32'hFFFF_0000;
  localparam logic [31:0] A_DATA  = 32'hFFFF_0004;
  localparam logic [31:0] A_TIMER = 32'hFFFF_0008;
  localparam logic [31:0] A_RAND  = 32'hFFFF_000C;
  localparam logic [31:0] A_LED   = 32'hFFFF_0010;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        key_valid;
  logic [7:0]  key_code;
  logic [7:0]  leds;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mips_dmem_responder #(
    .RAM_WORDS (64),
    .KEY_DEPTH (4),
    .LFSR_POLY (C_POLY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .aluout    (aluout),
    .writedata (writedata),
    .readdata  (readdata),
    .key_valid (key_valid),
    .key_code  (key_code),
    .leds      (leds)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ C_POLY) : (v >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read: expectation queued at drive time, popped when readdata settles.
  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    exp_t e;
    memwrite = 1'b0;
    aluout   = addr;
    sb_q.push_back('{tag, exp});
    #1;
    e = sb_q.pop_front();
    check_eq(e.tag, readdata, e.val);
  endtask

  task automatic chk_leds(input logic [7:0] exp, input string tag);
    exp_t e;
    sb_q.push_back('{tag, {24'h0, exp}});
    #1;
    e = sb_q.pop_front();
    check_eq(e.tag, {24'h0, leds}, e.val);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    aluout    = addr;
    writedata = data;
    memwrite  = 1'b1;
    tick();
    memwrite  = 1'b0;
  endtask

  task automatic key(input logic [7:0] code);
    key_valid = 1'b1;
    key_code  = code;
    tick();
    key_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t0;
    logic [31:0] r;
    reset = 1'b0; memwrite = 1'b0; aluout = 32'h0; writedata = 32'h0;
    key_valid = 1'b0; key_code = 8'h0;

    // 1: reset state, timer, LFSR
    repeat (3) @(posedge clk);
    @(negedge clk);
    rd(A_STAT, 32'h0, "rst_stat");
    chk_leds(8'h00, "rst_leds");
    reset = 1'b1;
    rd(A_RAND, 32'h1, "rst_rand");
    t0 = 32'h0;
    rd(A_TIMER, t0, "rst_timer");
    repeat (3) tick();
    rd(A_TIMER, t0 + 32'd3, "timer_plus3");

    // 2: RAM access, out-of-range addresses
    wr(32'h0000_0000, 32'h1111_1111);
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_rd10");
    rd(32'h0000_0013, 32'hDEAD_BEEF, "ram_rd13");
    wr(32'h0000_4000, 32'h1234_5678);
    rd(32'h0000_4000, 32'h0, "oob_rd4000");
    rd(32'h0000_0000, 32'h1111_1111, "ram_no_alias");
    rd(32'h0000_0100, 32'h0, "oob_rd100");
    rd(32'hFFFF_0014, 32'h0, "io_unmapped");

    // 3: key FIFO basic push/pop
    key(8'h1C); key(8'h1B); key(8'h23);
    rd(A_STAT, 32'h3, "fifo_stat3");
    rd(A_DATA, 32'h1C, "fifo_head1c");
    rd(A_DATA, 32'h1C, "fifo_rd_nopop");
    wr(A_DATA, 32'h0);
    rd(A_DATA, 32'h1B, "fifo_head1b");
    rd(A_STAT, 32'h2, "fifo_stat2");
    wr(A_DATA, 32'h0);
    wr(A_DATA, 32'h0);
    rd(A_DATA, 32'h0, "fifo_empty_data");
    wr(A_DATA, 32'h0);
    rd(A_STAT, 32'h0, "fifo_pop_empty");

    // 4: overflow, simultaneous pop+push, set-wins on ovf
    key(8'h01); key(8'h02); key(8'h03); key(8'h04); key(8'h05);
    rd(A_STAT, 32'h84, "ovf_stat84");
    rd(A_DATA, 32'h01, "ovf_head");
    wr(A_STAT, 32'h0);
    rd(A_STAT, 32'h04, "ovf_cleared");
    aluout = A_DATA; memwrite = 1'b1; key_valid = 1'b1; key_code = 8'h66;
    tick();
    memwrite = 1'b0; key_valid = 1'b0;
    rd(A_STAT, 32'h04, "popush_stat");
    rd(A_DATA, 32'h02, "popush_head");
    wr(A_DATA, 32'h0); wr(A_DATA, 32'h0); wr(A_DATA, 32'h0);
    rd(A_DATA, 32'h66, "popush_tail");
    rd(A_STAT, 32'h01, "popush_stat1");
    key(8'h07); key(8'h08); key(8'h09);
    aluout = A_STAT; memwrite = 1'b1; key_valid = 1'b1; key_code = 8'hAA;
    tick();
    memwrite = 1'b0; key_valid = 1'b0;
    rd(A_STAT, 32'h84, "ovf_set_wins");
    rd(A_DATA, 32'h66, "ovf_drop_head");
    wr(A_STAT, 32'h0);
    wr(A_DATA, 32'h0);
    rd(A_STAT, 32'h03, "fifo_stat3b");
    rd(A_DATA, 32'h07, "fifo_head07");

    // 5: RAND seed, TIMER wrap, LED write with same-cycle old read
    wr(A_RAND, 32'h0);
    rd(A_RAND, 32'h1, "rand_seed0");
    tick();
    rd(A_RAND, lfsr_next(32'h1), "rand_step1");
    wr(A_RAND, 32'h5);
    rd(A_RAND, 32'h5, "rand_seed5");
    tick();
    r = lfsr_next(32'h5);
    rd(A_RAND, r, "rand_step5");
    tick();
    rd(A_RAND, lfsr_next(r), "rand_step5b");
    wr(A_TIMER, 32'hFFFF_FFFF);
    rd(A_TIMER, 32'hFFFF_FFFF, "timer_load");
    tick();
    rd(A_TIMER, 32'h0, "timer_wrap");
    aluout = A_LED; writedata = 32'h1A5; memwrite = 1'b1;
    #1;
    check_eq("led_old_same_cycle", readdata, 32'h0);
    tick();
    memwrite = 1'b0;
    chk_leds(8'hA5, "leds_a5");
    rd(A_LED, 32'hA5, "led_rd");

    // 6: asynchronous reset mid-stream, no clock edge
    tick();
    reset = 1'b0;
    rd(A_STAT, 32'h0, "async_stat");
    chk_leds(8'h00, "async_leds");
    rd(A_TIMER, 32'h0, "async_timer");
    rd(A_RAND, 32'h1, "async_rand");
    tick();
    reset = 1'b1;
    rd(A_DATA, 32'h0, "post_rst_data");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
